// File: rtl/microcode.sv
// Stage-2 microcode word layout as seen by the memory path.
// Only the memory write-enable field is decoded by this block.
package microcode;

    localparam int WIDTH      = 8;
    localparam int MEM_WE_BIT = 0;

    function automatic logic mcs2_mem_we(input logic [WIDTH-1:0] mc);
        return mc[MEM_WE_BIT];
    endfunction

endpackage

// File: rtl/mmio_pkg.sv
// Shared word-map offsets and STATUS bit positions for the MMIO register file.
package mmio_pkg;

    // Offsets relative to NUM_OUT_REGS.
    localparam int CYCLE_OFS  = 0;
    localparam int TIMER_OFS  = 1;
    localparam int STATUS_OFS = 2;
    localparam int INPUT_OFS  = 3;

    localparam int STATUS_EXPIRED_BIT = 0;
    localparam int STATUS_RUNNING_BIT = 1;

endpackage

// File: rtl/mmio_regfile_if.sv
// Stage-2 memory bus as seen by the MMIO register file.
interface mmio_regfile_if;

    logic [microcode::WIDTH-1:0] microcode_s2;
    logic [31:0]                 addr;
    logic [31:0]                 data_in;
    logic [31:0]                 data_out;
    logic                        is_mmio;

    modport master (output microcode_s2, addr, data_in, input data_out, is_mmio);
    modport slave  (input microcode_s2, addr, data_in, output data_out, is_mmio);

endinterface

// File: rtl/mmio_timer.sv
// One-shot countdown timer with sticky EXPIRED flag; a load beats the decrement
// and an expiry beats a same-cycle clear.
module mmio_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_enable,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        clear,
    output logic [31:0] value,
    output logic        expired
);

    logic expire_now;

    assign expire_now = !load && (value == 32'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value   <= '0;
            expired <= 1'b0;
        end else if (clk_enable) begin
            if (load)
                value <= load_value;
            else if (value != 32'd0)
                value <= value - 32'd1;

            if (expire_now)
                expired <= 1'b1;
            else if (clear)
                expired <= 1'b0;
        end
    end

endmodule

// File: rtl/mmio_regfile.sv
// Memory-mapped register file: output regs, cycle counter, countdown timer, input reg.
// Optional MMIO_INPUT_SYNC_EN adds a 2-flop synchronizer on gpio_in.
module mmio_regfile
    import mmio_pkg::*;
#(
    parameter int MMIO_ADDR_START_BIT = 16,
    parameter int NUM_OUT_REGS        = 4,
    parameter int OUT_WIDTH           = 16,
    parameter int IN_WIDTH            = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clk_enable,
    mmio_regfile_if.slave                     bus,
    output logic [NUM_OUT_REGS*OUT_WIDTH-1:0] out_regs,
    input  logic [IN_WIDTH-1:0]               gpio_in,
    output logic                              timer_irq
);

    localparam int IDX_W = MMIO_ADDR_START_BIT - 3;
    localparam logic [IDX_W-1:0] IDX_CYCLE  = IDX_W'(NUM_OUT_REGS + CYCLE_OFS);
    localparam logic [IDX_W-1:0] IDX_TIMER  = IDX_W'(NUM_OUT_REGS + TIMER_OFS);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_OUT_REGS + STATUS_OFS);
    localparam logic [IDX_W-1:0] IDX_INPUT  = IDX_W'(NUM_OUT_REGS + INPUT_OFS);

    logic [IDX_W-1:0]     idx;
    logic                 access;
    logic                 we;
    logic [OUT_WIDTH-1:0] out_q [NUM_OUT_REGS];
    logic [31:0]          cycle_q;
    logic [31:0]          timer_value;
    logic                 timer_expired;
    logic [IN_WIDTH-1:0]  in_value;
    logic [31:0]          status_word;
    logic [31:0]          rdata;
    logic                 unused_addr_bits;

    assign bus.is_mmio      = bus.addr[MMIO_ADDR_START_BIT];
    assign idx              = bus.addr[MMIO_ADDR_START_BIT-2:2];
    assign access           = clk_enable && bus.is_mmio;
    assign we               = access && microcode::mcs2_mem_we(bus.microcode_s2);
    assign unused_addr_bits = ^{bus.addr[31:MMIO_ADDR_START_BIT+1], bus.addr[1:0]};

    mmio_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .load       (we && (idx == IDX_TIMER)),
        .load_value (bus.data_in),
        .clear      (we && (idx == IDX_STATUS) && bus.data_in[STATUS_EXPIRED_BIT]),
        .value      (timer_value),
        .expired    (timer_expired)
    );

    assign timer_irq = timer_expired;

`ifdef MMIO_INPUT_SYNC_EN
    logic [IN_WIDTH-1:0] sync1_q;
    logic [IN_WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else if (clk_enable) begin
            sync1_q <= gpio_in;
            sync2_q <= sync1_q;
        end
    end

    assign in_value = sync2_q;
`else
    assign in_value = gpio_in;
`endif

    always_comb begin
        // NOTE: defaults first keep every path assigned, so no latch is inferred.
        status_word                     = '0;
        status_word[STATUS_EXPIRED_BIT] = timer_expired;
        status_word[STATUS_RUNNING_BIT] = (timer_value != 32'd0);

        rdata = '0;
        for (int i = 0; i < NUM_OUT_REGS; i++)
            if (idx == IDX_W'(i)) rdata = 32'(out_q[i]);
        if (idx == IDX_CYCLE)  rdata = cycle_q;
        if (idx == IDX_TIMER)  rdata = timer_value;
        if (idx == IDX_STATUS) rdata = status_word;
        if (idx == IDX_INPUT)  rdata = 32'(in_value);
    end

    // NOTE: the output register array is small and software-visible, so it is reset like any other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_OUT_REGS; i++) out_q[i] <= '0;
            cycle_q      <= '0;
            bus.data_out <= '0;
        end else if (clk_enable) begin
            cycle_q <= cycle_q + 32'd1;
            // rdata reflects pre-edge state, so a write returns the old value.
            if (access)
                bus.data_out <= rdata;
            if (we)
                for (int i = 0; i < NUM_OUT_REGS; i++)
                    if (idx == IDX_W'(i)) out_q[i] <= bus.data_in[OUT_WIDTH-1:0];
        end
    end

    for (genvar g = 0; g < NUM_OUT_REGS; g++) begin : g_out
        assign out_regs[g*OUT_WIDTH +: OUT_WIDTH] = out_q[g];
    end

endmodule

// File: tb/tb_mmio_regfile.sv
// Self-checking bench for mmio_regfile: read data is checked through an
// expected-value queue filled when each read is issued.
module tb_mmio_regfile;

    localparam int N = 4;
    localparam logic [31:0] MMIO = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_enable = 1'b0;
    logic [63:0] out_regs;
    logic [15:0] gpio_in = '0;
    logic        timer_irq;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] cyc_model;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    mmio_regfile_if bus ();

    mmio_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .bus        (bus),
        .out_regs   (out_regs),
        .gpio_in    (gpio_in),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference count of enabled edges since reset.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc_model <= '0;
        else if (clk_enable) cyc_model <= cyc_model + 32'd1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; performs one access edge and returns at the next negedge.
    task automatic acc(input bit wr, input int idx, input logic [31:0] wdata,
                       input bit rd, input logic [31:0] exp, input string tag);
        bus.addr         = MMIO | (32'(idx) << 2);
        bus.microcode_s2 = wr ? 8'h01 : 8'h00;
        bus.data_in      = wdata;
        clk_enable       = 1'b1;
        if (rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        #1;
        bus.addr         = '0;
        bus.microcode_s2 = '0;
        bus.data_in      = '0;
        if (rd && exp_q.size() > 0) check(tag_q.pop_front(), 64'(bus.data_out), 64'(exp_q.pop_front()));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clk_enable = 1'b1;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.addr = '0;
        bus.microcode_s2 = '0;
        bus.data_in = '0;
        #1;
        check("rst_out_regs", out_regs, 64'h0);
        check("rst_data_out", 64'(bus.data_out), 64'h0);
        check("rst_irq", 64'(timer_irq), 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Cycle counter: 10 enabled edges, then read at the 11th edge.
        idle(10);
        acc(0, N, 0, 1, 32'd10, "cycle_10");
        // Disabled cycles with a pending write: nothing may move.
        bus.addr = MMIO;
        bus.microcode_s2 = 8'h01;
        bus.data_in = 32'hFFFF_FFFF;
        clk_enable = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.addr = '0;
        bus.microcode_s2 = '0;
        check("frozen_out_regs", out_regs, 64'h0);
        check("frozen_data_out", 64'(bus.data_out), 64'd10);
        acc(0, N, 0, 1, 32'd11, "cycle_frozen");

        // Output registers, truncation and zero-extension.
        acc(1, 2, 32'h1234_ABCD, 0, 0, "");
        check("out2_bits", 64'(out_regs[47:32]), 64'hABCD);
        acc(0, 2, 0, 1, 32'h0000_ABCD, "rd_out2");
        acc(0, 1, 0, 1, 32'h0, "rd_out1");
        acc(1, 0, 32'h0000_5A5A, 1, 32'h0, "wr_out0_old");
        acc(1, 3, 32'hFFFF_8001, 0, 0, "");
        check("out_regs_all", out_regs, 64'h8001_ABCD_0000_5A5A);
        acc(0, 3, 0, 1, 32'h0000_8001, "rd_out3");

        // is_mmio decode; non-MMIO writes are ignored.
        bus.addr = 32'h0000_0008;
        bus.microcode_s2 = 8'h01;
        bus.data_in = 32'h0000_1111;
        #1 check("is_mmio_lo", 64'(bus.is_mmio), 64'h0);
        @(posedge clk);
        #1 check("non_mmio_write", out_regs, 64'h8001_ABCD_0000_5A5A);
        bus.addr = MMIO | 32'h8;
        bus.microcode_s2 = '0;
        #1 check("is_mmio_hi", 64'(bus.is_mmio), 64'h1);
        bus.addr = '0;
        @(negedge clk);

        // Countdown from 3.
        acc(1, N+1, 32'd3, 0, 0, "");
        acc(0, N+2, 0, 1, 32'h2, "status_running");
        check("irq_run1", 64'(timer_irq), 64'h0);
        idle(1);
        check("irq_run2", 64'(timer_irq), 64'h0);
        idle(1);
        check("irq_expired", 64'(timer_irq), 64'h1);
        acc(0, N+2, 0, 1, 32'h1, "status_expired");
        acc(1, N+2, 32'h0, 0, 0, "");
        check("w0_no_clear", 64'(timer_irq), 64'h1);
        acc(1, N+2, 32'h1, 0, 0, "");
        check("w1c_clear", 64'(timer_irq), 64'h0);

        // Expiry coinciding with W1C: set wins.
        acc(1, N+1, 32'd2, 0, 0, "");
        idle(1);
        acc(1, N+2, 32'h1, 0, 0, "");
        check("expire_beats_clear", 64'(timer_irq), 64'h1);
        acc(1, N+2, 32'h1, 0, 0, "");
        check("clear_after", 64'(timer_irq), 64'h0);

        // Reload while running, then stop with a load of 0.
        acc(1, N+1, 32'd5, 0, 0, "");
        acc(1, N+1, 32'd100, 0, 0, "");
        acc(0, N+1, 0, 1, 32'd100, "timer_reload");
        acc(1, N+1, 32'd0, 1, 32'd99, "timer_pre_stop");
        idle(4);
        acc(0, N+2, 0, 1, 32'h0, "status_stopped");
        check("irq_stopped", 64'(timer_irq), 64'h0);

        // Input register.
        gpio_in = 16'h00F0;
`ifdef MMIO_INPUT_SYNC_EN
        acc(0, N+3, 0, 1, 32'h0, "input_old");
`else
        acc(0, N+3, 0, 1, 32'h0000_00F0, "input_direct");
`endif
        idle(2);
        acc(0, N+3, 0, 1, 32'h0000_00F0, "input_settled");

        // Unmapped index and read-only CYCLE write.
        acc(1, 9, 32'hDEAD_BEEF, 1, 32'h0, "unmapped_wr");
        acc(0, 9, 0, 1, 32'h0, "unmapped_rd");
        acc(1, N, 32'h0, 0, 0, "");
        acc(0, N, 0, 1, cyc_model, "cycle_ro");

        // Reset in the middle of a countdown.
        acc(0, 2, 0, 1, 32'h0000_ABCD, "rd_before_rst");
        acc(1, N+1, 32'd5, 0, 0, "");
        #2 rst = 1'b1;
        #1;
        check("midrst_out_regs", out_regs, 64'h0);
        check("midrst_data_out", 64'(bus.data_out), 64'h0);
        check("midrst_irq", 64'(timer_irq), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(8);
        check("midrst_no_irq", 64'(timer_irq), 64'h0);
        acc(0, N+1, 0, 1, 32'h0, "midrst_timer");
        acc(0, N, 0, 1, 32'd9, "midrst_cycle");

        if (exp_q.size() != 0) check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
